// File: rtl/udm_bus_arb2.sv
// Two-master, one-slave round-robin arbiter for the udm request/ack/resp bus.
// Outstanding reads are tracked in order so each response returns to its issuer.
module udm_bus_arb2 #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned OUTST_DEPTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,

    input  logic                            m0_req_i,
    input  logic                            m0_we_i,
    input  logic [ADDR_WIDTH-1:0]           m0_addr_bi,
    input  logic [DATA_WIDTH/8-1:0]         m0_be_bi,
    input  logic [DATA_WIDTH-1:0]           m0_wdata_bi,
    output logic                            m0_ack_o,
    output logic                            m0_resp_o,
    output logic [DATA_WIDTH-1:0]           m0_rdata_bo,

    input  logic                            m1_req_i,
    input  logic                            m1_we_i,
    input  logic [ADDR_WIDTH-1:0]           m1_addr_bi,
    input  logic [DATA_WIDTH/8-1:0]         m1_be_bi,
    input  logic [DATA_WIDTH-1:0]           m1_wdata_bi,
    output logic                            m1_ack_o,
    output logic                            m1_resp_o,
    output logic [DATA_WIDTH-1:0]           m1_rdata_bo,

    output logic                            s_req_o,
    output logic                            s_we_o,
    output logic [ADDR_WIDTH-1:0]           s_addr_bo,
    output logic [DATA_WIDTH/8-1:0]         s_be_bo,
    output logic [DATA_WIDTH-1:0]           s_wdata_bo,
    input  logic                            s_ack_i,
    input  logic                            s_resp_i,
    input  logic [DATA_WIDTH-1:0]           s_rdata_bi,

    output logic [$clog2(OUTST_DEPTH):0]    outst_cnt_o,
    output logic                            err_o
);

    localparam int unsigned PtrW = $clog2(OUTST_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic                   prio_q;
    logic [OUTST_DEPTH-1:0] id_q;
    logic [PtrW-1:0]        wr_ptr_q;
    logic [PtrW-1:0]        rd_ptr_q;
    logic [CntW-1:0]        cnt_q;
    logic                   err_q;

    logic full;
    logic empty;
    logic elig0;
    logic elig1;
    logic win_valid;
    logic win_id;
    logic accept;
    logic push;
    logic pop;
    logic head_id;

    // Full uses the registered count, so a same-cycle pop does not unblock reads.
    assign full  = (cnt_q == CntW'(OUTST_DEPTH));
    assign empty = (cnt_q == '0);
    assign elig0 = m0_req_i && (m0_we_i || !full);
    assign elig1 = m1_req_i && (m1_we_i || !full);

    assign win_valid = !rst_i && (elig0 || elig1);
    assign win_id    = (elig0 && elig1) ? prio_q : elig1;
    assign head_id   = id_q[rd_ptr_q];

    assign accept = win_valid && s_ack_i;
    assign push   = accept && !s_we_o;
    assign pop    = !rst_i && s_resp_i && !empty;

    always_comb begin
        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_bo  = '0;
        s_be_bo    = '0;
        s_wdata_bo = '0;
        if (win_valid) begin
            s_req_o = 1'b1;
            if (win_id) begin
                s_we_o     = m1_we_i;
                s_addr_bo  = m1_addr_bi;
                s_be_bo    = m1_be_bi;
                s_wdata_bo = m1_wdata_bi;
            end else begin
                s_we_o     = m0_we_i;
                s_addr_bo  = m0_addr_bi;
                s_be_bo    = m0_be_bi;
                s_wdata_bo = m0_wdata_bi;
            end
        end
    end

    always_comb begin
        m0_ack_o    = accept && !win_id;
        m1_ack_o    = accept && win_id;
        m0_resp_o   = 1'b0;
        m1_resp_o   = 1'b0;
        m0_rdata_bo = '0;
        m1_rdata_bo = '0;
        if (pop) begin
            if (head_id) begin
                m1_resp_o   = 1'b1;
                m1_rdata_bo = s_rdata_bi;
            end else begin
                m0_resp_o   = 1'b1;
                m0_rdata_bo = s_rdata_bi;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q   <= 1'b0;
            id_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                prio_q <= !win_id;
            end
            if (push) begin
                id_q[wr_ptr_q] <= win_id;
                wr_ptr_q       <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
            // A response with nothing outstanding is latched until reset.
            if (s_resp_i && empty) begin
                err_q <= 1'b1;
            end
        end
    end

    assign outst_cnt_o = cnt_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_udm_bus_arb2.sv
// Bench for udm_bus_arb2: directed scenarios plus random traffic, checked against
// a queue-based model of the arbitration and response-routing rules.
module tb_udm_bus_arb2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int D  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [BW-1:0] m0_be, m1_be;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m0_resp, m1_ack, m1_resp;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_req, s_we, s_ack, s_resp;
    logic [AW-1:0] s_addr;
    logic [BW-1:0] s_be;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [2:0]    outst_cnt;
    logic          err;

    udm_bus_arb2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUTST_DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_bi(m0_addr), .m0_be_bi(m0_be),
        .m0_wdata_bi(m0_wdata), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_bo(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_bi(m1_addr), .m1_be_bi(m1_be),
        .m1_wdata_bi(m1_wdata), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_bo(m1_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_bo(s_be),
        .s_wdata_bo(s_wdata), .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
        .outst_cnt_o(outst_cnt), .err_o(err)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: in-order issuer IDs, round-robin favourite, sticky error.
    int   q[$];
    int   prio_m = 0;
    bit   err_m  = 0;
    int   cyc    = 0;

    // Auto-responding slave: answers each accepted read two cycles later with data=addr.
    bit          auto_slave = 0;
    int          lat_q[$];
    logic [31:0] dat_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_inputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_be = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_be = '0; m1_wdata = '0;
        s_ack = 0; s_resp = 0; s_rdata = '0;
    endtask

    // One clock: settle, compare every output with the model, then advance the model.
    task automatic cycle();
        int          win;
        int          rid;
        bit          e0, e1, full, wwe;
        logic [63:0] waddr, wbe, wwd;
        if (auto_slave) begin
            s_resp  = (lat_q.size() > 0) && (lat_q[0] + 2 <= cyc);
            s_rdata = s_resp ? dat_q[0] : $urandom;
        end
        #1;
        full = (q.size() == D);
        e0   = m0_req && (m0_we || !full);
        e1   = m1_req && (m1_we || !full);
        win  = -1;
        if (e0 && e1) win = prio_m;
        else if (e0)  win = 0;
        else if (e1)  win = 1;
        if (rst) win = -1;
        wwe = 0; waddr = 0; wbe = 0; wwd = 0;
        if (win == 0) begin wwe = m0_we; waddr = m0_addr; wbe = m0_be; wwd = m0_wdata; end
        if (win == 1) begin wwe = m1_we; waddr = m1_addr; wbe = m1_be; wwd = m1_wdata; end
        rid = (!rst && s_resp && q.size() > 0) ? q[0] : -1;

        chk("s_req",    s_req,    win >= 0);
        chk("s_we",     s_we,     wwe);
        chk("s_addr",   s_addr,   waddr);
        chk("s_be",     s_be,     wbe);
        chk("s_wdata",  s_wdata,  wwd);
        chk("m0_ack",   m0_ack,   win == 0 && s_ack);
        chk("m1_ack",   m1_ack,   win == 1 && s_ack);
        chk("m0_resp",  m0_resp,  rid == 0);
        chk("m1_resp",  m1_resp,  rid == 1);
        chk("m0_rdata", m0_rdata, rid == 0 ? 64'(s_rdata) : 64'd0);
        chk("m1_rdata", m1_rdata, rid == 1 ? 64'(s_rdata) : 64'd0);
        chk("outst",    outst_cnt, q.size());
        chk("err",      err,      err_m);

        @(posedge clk);
        if (rst) begin
            q.delete(); prio_m = 0; err_m = 0;
        end else begin
            if (s_resp) begin
                if (q.size() > 0) void'(q.pop_front());
                else err_m = 1;
            end
            if (win >= 0 && s_ack) begin
                if (!wwe) begin
                    q.push_back(win);
                    if (auto_slave) begin lat_q.push_back(cyc); dat_q.push_back(waddr[31:0]); end
                end
                prio_m = 1 - win;
            end
        end
        if (auto_slave && s_resp) begin void'(lat_q.pop_front()); void'(dat_q.pop_front()); end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; cycle(); rst = 0;
    endtask

    task automatic drain();
        clr_inputs();
        for (int i = 0; i < D + 2 && q.size() > 0; i++) begin
            s_resp = 1; s_rdata = $urandom; cycle();
        end
        s_resp = 0;
        chk("drained", outst_cnt, 0);
    endtask

    initial begin
        clr_inputs();
        rst = 1;
        @(negedge clk);
        // Reset with busy inputs: every handshake and slave output must be 0.
        m0_req = 1; m1_req = 1; m0_addr = 32'hdead; m1_addr = 32'hbeef; s_ack = 1;
        s_resp = 1; s_rdata = 32'h5555;
        cycle(); cycle();
        rst = 0; clr_inputs();
        chk("rst_cnt", outst_cnt, 0);
        chk("rst_err", err, 0);

        // Single m0 write.
        m0_req = 1; m0_we = 1; m0_addr = 32'h0; m0_be = 4'hf; m0_wdata = 32'h1234; s_ack = 1;
        #1;
        chk("t1_m0_ack", m0_ack, 1);
        chk("t1_s_we", s_we, 1);
        cycle();
        chk("t1_cnt", outst_cnt, 0);
        clr_inputs();

        // Both masters reading continuously, slave acks every cycle.
        auto_slave = 1;
        for (int i = 0; i < 12; i++) begin
            m0_req = 1; m0_we = 0; m0_addr = 32'h1000 + i; m0_be = 4'hf;
            m1_req = 1; m1_we = 0; m1_addr = 32'h2000 + i; m1_be = 4'h3;
            s_ack = 1;
            cycle();
        end
        m0_req = 0; m1_req = 0; s_ack = 0;
        for (int i = 0; i < 6 && lat_q.size() > 0; i++) cycle();
        auto_slave = 0;
        chk("t2_cnt", outst_cnt, 0);
        clr_inputs();

        // Fill the read tracker from m1.
        m1_req = 1; m1_addr = 32'h8000_0000; m1_be = 4'hf; s_ack = 1;
        for (int i = 0; i < D; i++) cycle();
        #1;
        chk("t3_full_cnt", outst_cnt, D);
        chk("t3_m1_blocked", m1_ack, 0);
        m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'hcafe; m0_be = 4'hf;
        #1;
        chk("t3_wr_while_full", m0_ack, 1);
        cycle();
        m0_req = 0; s_resp = 1; s_rdata = 32'h0bad_f00d;
        #1;
        chk("t3_pop_resp", m1_resp, 1);
        chk("t3_still_blocked", m1_ack, 0);
        cycle();
        s_resp = 0;
        #1;
        chk("t3_cnt3", outst_cnt, D - 1);
        chk("t3_unblocked", m1_ack, 1);
        cycle();
        drain();

        // Slave stalls with both masters requesting; first ack goes to m0.
        do_reset();
        m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20; s_ack = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_no_ack", m0_ack | m1_ack, 0);
            cycle();
        end
        s_ack = 1;
        #1;
        chk("t4_m0_first", m0_ack, 1);
        cycle();
        drain();

        // Stray response, then normal traffic: error stays set.
        clr_inputs();
        s_resp = 1; s_rdata = 32'h77;
        cycle();
        s_resp = 0;
        chk("t5_err_set", err, 1);
        m0_req = 1; m0_addr = 32'h44; s_ack = 1;
        cycle();
        drain();
        chk("t5_err_sticky", err, 1);

        // Reset with two reads outstanding, then a late response.
        do_reset();
        m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200; s_ack = 1;
        cycle(); cycle();
        chk("t6_two_out", outst_cnt, 2);
        rst = 1;
        cycle();
        rst = 0; clr_inputs();
        chk("t6_cnt_cleared", outst_cnt, 0);
        chk("t6_err_clear", err, 0);
        s_resp = 1; s_rdata = 32'h200;
        cycle();
        s_resp = 0;
        chk("t6_late_err", err, 1);

        // Random traffic; the slave only responds when something is outstanding.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            m0_req   = 1'($urandom); m0_we = 1'($urandom); m0_addr = $urandom;
            m0_be    = 4'($urandom); m0_wdata = $urandom;
            m1_req   = 1'($urandom); m1_we = 1'($urandom); m1_addr = $urandom;
            m1_be    = 4'($urandom); m1_wdata = $urandom;
            s_ack    = ($urandom_range(0, 3) != 0);
            s_resp   = (q.size() > 0) && ($urandom_range(0, 2) != 0);
            s_rdata  = $urandom;
            cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/udm_bus_arb2.md
Name: udm_bus_arb2

Overview:
- Two-master, one-slave arbiter for the udm-style request/ack/resp bus.
- Lets the UDM debug master (m0) and a second master (m1, e.g. a CPU data port) share one slave address space: CSR decoder plus test memory.
- Arbitrates round-robin per accepted transfer.
- Tracks outstanding reads in order and routes each slave response back to the master that issued the read.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width; byte-enable width is DATA_WIDTH/8.
- OUTST_DEPTH, 4, maximum outstanding reads; must be a power of 2, at least 2.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- m0_req_i  in  1  master 0 request.
- m0_we_i  in  1  master 0 write (1) / read (0).
- m0_addr_bi  in  ADDR_WIDTH  master 0 address.
- m0_be_bi  in  DATA_WIDTH/8  master 0 byte enables.
- m0_wdata_bi  in  DATA_WIDTH  master 0 write data.
- m0_ack_o  out  1  master 0 request accepted this cycle.
- m0_resp_o  out  1  master 0 read data valid.
- m0_rdata_bo  out  DATA_WIDTH  master 0 read data.
- m1_req_i, m1_we_i, m1_addr_bi, m1_be_bi, m1_wdata_bi, m1_ack_o, m1_resp_o, m1_rdata_bo: identical to m0 signals, for master 1.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write.
- s_addr_bo  out  ADDR_WIDTH  slave address.
- s_be_bo  out  DATA_WIDTH/8  slave byte enables.
- s_wdata_bo  out  DATA_WIDTH  slave write data.
- s_ack_i  in  1  slave accepted request.
- s_resp_i  in  1  slave read response valid.
- s_rdata_bi  in  DATA_WIDTH  slave read data.
- outst_cnt_o  out  log2(OUTST_DEPTH)+1  number of outstanding reads.
- err_o  out  1  sticky: a response arrived with no outstanding read.

Behaviour:
- Reset (rst_i=1 at clk edge): prio pointer=0 (m0 favoured), ID FIFO emptied, outst_cnt_o=0, err_o=0.
  - While rst_i=1, all ack/resp/req outputs are forced 0 and all data/address outputs are 0.
  - Reads outstanding at reset are discarded; their later responses set err_o.
- Eligibility (combinational): mX eligible = mX_req_i && (mX_we_i || full==0).
  - full = (registered count == OUTST_DEPTH).
  - Writes are never blocked by full.
- Grant (combinational, same cycle):
  - Only one eligible master: it wins.
  - Both eligible: the master named by prio wins.
  - None eligible: no winner, s_req_o=0, slave outputs 0.
- Slave drive: s_req_o=1 when a winner exists; s_we/addr/be/wdata are copied from the winner.
- Handshake:
  - mX_ack_o = winner==X && s_ack_i; zero-latency, combinational from s_ack_i.
  - The losing master sees ack=0 and must hold its request stable.
- Prio update: on an accepted transfer (s_req_o && s_ack_i), prio <= the non-winner. Otherwise prio holds.
- Read tracking:
  - An accepted read pushes the winner ID (1 bit) into an in-order FIFO of depth OUTST_DEPTH.
  - Accepted writes push nothing; writes have no response.
- Response routing:
  - On s_resp_i with FIFO non-empty: pop the head ID, assert m<id>_resp_o=1 and m<id>_rdata_bo=s_rdata_bi in the same cycle (combinational).
  - The other master's resp=0 and rdata=0.
  - Response latency added by the arbiter is 0 cycles.
- Stray response: s_resp_i with FIFO empty means no pop, no mX_resp_o, and err_o <= 1. err_o is sticky until reset.
- Counter: count <= count + push - pop. Push and pop in the same cycle leave count unchanged.
- Boundaries:
  - Full with a simultaneous pop: reads stay blocked that cycle, because full uses the registered count; they are eligible next cycle.
  - Empty with a simultaneous push and s_resp_i: treated as stray (err_o set), push still completes. A slave never responds in the acceptance cycle.
  - FIFO pointers wrap modulo OUTST_DEPTH.
  - Slave data is a don't-care to the arbiter when s_ack_i=0.

Test Plan:
- Single master m0 write, addr 0x0, wdata 0x1234, s_ack_i=1 -> s_we_o=1, s_addr_bo=0x0, m0_ack_o=1 same cycle, m1_ack_o=0, outst_cnt_o stays 0.
- Both masters reading continuously; slave acks every cycle and responds 2 cycles later with data=addr -> grants alternate m0,m1,m0,...; each resp reaches the issuing master with its own address as data.
- Reads to 0x80000000 from m1 with s_resp_i held 0, OUTST_DEPTH=4:
  - 4 acks, then outst_cnt_o=4 and m1_ack_o=0.
  - m0 write still acked while full.
  - One s_resp_i -> count 3, m1 read acked next cycle.
- s_ack_i=0 for 3 cycles with both requesting -> no acks, prio unchanged; ack on cycle 4 goes to the prio-0 master m0 first.
- s_resp_i pulse with no outstanding reads -> no mX_resp_o, err_o=1 and stays 1 through subsequent normal traffic.
- Assert rst_i with 2 reads outstanding, then a late s_resp_i -> outputs 0 during reset, outst_cnt_o=0 after, late response sets err_o=1.
